// File: rtl/signal_table_pwm_player_pkg.sv
// signal_table_pwm_player_pkg: shared state encoding and PWM period helper
package signal_table_pwm_player_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;
    // Final counter value of a PWM period lasting 2^dw-1 cycles
    function automatic int pwm_last(input int dw);
        return (1 << dw) - 2;
    endfunction
endpackage

// File: rtl/signal_table_pwm_player_pwm_comparator.sv
// signal_table_pwm_player_pwm_comparator: period counter, duty register and registered PWM compare
module signal_table_pwm_player_pwm_comparator
    import signal_table_pwm_player_pkg::*;
#(
    parameter int data_width = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  load,
    input  logic                  run,
    input  logic [data_width-1:0] dutyIn,
    output logic                  pwmOut,
    output logic                  last,
    output logic [data_width-1:0] cnt
);
    localparam logic [data_width-1:0] CNT_LAST = data_width'(pwm_last(data_width));
    logic [data_width-1:0] r_cnt;
    logic [data_width-1:0] r_duty;
    logic                  r_pwm;
    assign last   = r_cnt == CNT_LAST;
    assign cnt    = r_cnt;
    assign pwmOut = r_pwm;
    // Compare runs one cycle behind the counter; a load restarts the period with a fresh duty
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_cnt  <= '0;
            r_duty <= '0;
            r_pwm  <= 1'b0;
        end else begin
            r_pwm <= run && (r_cnt < r_duty);
            if (load) begin
                r_cnt  <= '0;
                r_duty <= dutyIn;
            end else begin
                r_cnt <= (run && !last) ? r_cnt + 1'b1 : '0;
            end
        end
    end
endmodule

// File: rtl/signal_table_pwm_player.sv
// signal_table_pwm_player: walks the signal table cyclically, playing each sample as one PWM period
module signal_table_pwm_player
    import signal_table_pwm_player_pkg::*;
#(
    parameter int data_width = 8,
    parameter int addr_width = 7,
    parameter int data_range = 100
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  En,
    input  logic [data_width-1:0] dataIn,
    output logic [addr_width-1:0] address,
    output logic                  WR,
    output logic                  pwmOut,
    output logic [addr_width-1:0] sampleIdx,
    output logic                  periodDone,
    output logic                  cycleDone,
    output logic                  busy
);
    localparam logic [addr_width-1:0] LAST_IDX = addr_width'(data_range - 1);
    localparam logic [data_width-1:0] CNT_PRE  = data_width'(pwm_last(data_width) - 1);
    state_t                r_state;
    logic [addr_width-1:0] r_address;
    logic [addr_width-1:0] r_sample_idx;
    logic [data_width-1:0] r_next_duty;
    logic                  r_period_done;
    logic                  r_cycle_done;
    logic                  r_busy;
    logic [data_width-1:0] w_cnt;
    logic [data_width-1:0] w_duty_in;
    logic [addr_width-1:0] w_next_addr;
    logic                  w_last;
    logic                  w_load;
    logic                  w_run;
    logic                  w_stop;
    assign w_stop      = r_state == RUN && w_last && !En;
    assign w_run       = r_state == RUN && !w_stop;
    assign w_load      = r_state == PRIME || (r_state == RUN && w_last && En);
    assign w_duty_in   = r_state == PRIME ? dataIn : r_next_duty;
    assign w_next_addr = r_sample_idx == LAST_IDX ? '0 : r_sample_idx + 1'b1;
    assign address     = r_address;
    assign sampleIdx   = r_sample_idx;
    assign periodDone  = r_period_done;
    assign cycleDone   = r_cycle_done;
    assign busy        = r_busy;
    assign WR          = 1'b0;

    signal_table_pwm_player_pwm_comparator #(.data_width(data_width)) u_cmp (
        .Clk   (Clk),
        .Rst   (Rst),
        .load  (w_load),
        .run   (w_run),
        .dutyIn(w_duty_in),
        .pwmOut(pwmOut),
        .last  (w_last),
        .cnt   (w_cnt)
    );

    // Sequencer: prefetch the next sample early in each period, swap it in on the last cycle
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state       <= IDLE;
            r_address     <= '0;
            r_sample_idx  <= '0;
            r_next_duty   <= '0;
            r_period_done <= 1'b0;
            r_cycle_done  <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_period_done <= r_state == RUN && w_cnt == CNT_PRE;
            r_cycle_done  <= r_state == RUN && w_cnt == CNT_PRE && r_sample_idx == LAST_IDX;
            case (r_state)
                IDLE: begin
                    r_address <= '0;
                    if (En) begin
                        r_state <= PRIME;
                        r_busy  <= 1'b1;
                    end
                end
                PRIME: begin
                    r_state      <= RUN;
                    r_sample_idx <= '0;
                end
                RUN: begin
                    if (w_cnt == '0) r_address <= w_next_addr;
                    if (w_cnt == data_width'(1)) r_next_duty <= dataIn;
                    if (w_last) begin
                        if (En) begin
                            r_sample_idx <= r_address;
                        end else begin
                            r_state   <= IDLE;
                            r_address <= '0;
                            r_busy    <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_signal_table_pwm_player.sv
// tb_signal_table_pwm_player: randomized playback checks against an arithmetic table/period model
module tb_signal_table_pwm_player;
    localparam int PER = 255;
    localparam int RNG = 100;
    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       En = 1'b0;
    logic       En1 = 1'b0;
    logic [7:0] tbl [128];
    logic [7:0] tbl1_0 = 8'd10;
    logic [7:0] dataIn, dataIn1;
    logic [6:0] address, sampleIdx, address1, sampleIdx1;
    logic       WR, pwmOut, periodDone, cycleDone, busy;
    logic       WR1, pwmOut1, periodDone1, cycleDone1, busy1;
    int         n_checks = 0;
    int         n_fail = 0;

    assign dataIn  = tbl[address];
    assign dataIn1 = tbl1_0;
    always #5 Clk = ~Clk;

    signal_table_pwm_player dut (
        .Clk(Clk), .Rst(Rst), .En(En), .dataIn(dataIn), .address(address), .WR(WR),
        .pwmOut(pwmOut), .sampleIdx(sampleIdx), .periodDone(periodDone),
        .cycleDone(cycleDone), .busy(busy)
    );

    signal_table_pwm_player #(.data_range(1)) dut1 (
        .Clk(Clk), .Rst(Rst), .En(En1), .dataIn(dataIn1), .address(address1), .WR(WR1),
        .pwmOut(pwmOut1), .sampleIdx(sampleIdx1), .periodDone(periodDone1),
        .cycleDone(cycleDone1), .busy(busy1)
    );

    // Output cycle j (counted from the first RUN cycle) shows the compare of cycle j-1
    function automatic bit exp_pwm(input int j);
        if (j == 0) return 1'b0;
        return ((j - 1) % PER) < int'(tbl[((j - 1) / PER) % RNG]);
    endfunction

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b1;
        En  = 1'b0;
        En1 = 1'b0;
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        #1 Rst = 1'b1;
        #1;
        n_checks++;
        if ({address, sampleIdx, pwmOut, periodDone, cycleDone, busy, WR} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got addr=%0d idx=%0d pwm=%b pd=%b cd=%b busy=%b wr=%b want all 0",
                     address, sampleIdx, pwmOut, periodDone, cycleDone, busy, WR);
        end
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        n_checks++;
        if (busy !== 1'b0 || address !== 7'd0) begin
            n_fail++;
            $display("FAIL idle_hold got busy=%b addr=%0d want 0 0", busy, address);
        end
    endtask

    task automatic test_playback(input int nper);
        int k, c, ea, pd_cnt, cd_cnt;
        int hi [128];
        pd_cnt = 0;
        cd_cnt = 0;
        for (int i = 0; i < 128; i++) hi[i] = 0;
        @(negedge Clk);
        En = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        for (int j = 0; j <= nper * PER; j++) begin
            @(negedge Clk);
            k  = (j / PER) % RNG;
            c  = j % PER;
            ea = (c == 0) ? k : (k == RNG - 1 ? 0 : k + 1);
            if (j > 0 && pwmOut === 1'b1) hi[(j - 1) / PER]++;
            if (periodDone === 1'b1) pd_cnt++;
            if (cycleDone === 1'b1) cd_cnt++;
            n_checks++;
            if (pwmOut !== exp_pwm(j)) begin
                n_fail++;
                $display("FAIL pwm j=%0d got %b want %b", j, pwmOut, exp_pwm(j));
            end
            n_checks++;
            if (address !== 7'(ea)) begin
                n_fail++;
                $display("FAIL address j=%0d got %0d want %0d", j, address, ea);
            end
            n_checks++;
            if (sampleIdx !== 7'(k)) begin
                n_fail++;
                $display("FAIL sample_idx j=%0d got %0d want %0d", j, sampleIdx, k);
            end
            n_checks++;
            if (periodDone !== (c == PER - 1)) begin
                n_fail++;
                $display("FAIL period_done j=%0d got %b want %b", j, periodDone, c == PER - 1);
            end
            n_checks++;
            if (cycleDone !== (c == PER - 1 && k == RNG - 1)) begin
                n_fail++;
                $display("FAIL cycle_done j=%0d got %b want %b", j, cycleDone, c == PER - 1 && k == RNG - 1);
            end
            n_checks++;
            if (busy !== 1'b1 || WR !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_wr j=%0d got busy=%b wr=%b want 1 0", j, busy, WR);
            end
        end
        for (int p = 0; p < nper; p++) begin
            n_checks++;
            if (hi[p] != int'(tbl[p % RNG])) begin
                n_fail++;
                $display("FAIL high_cycles period=%0d got %0d want %0d", p, hi[p], tbl[p % RNG]);
            end
        end
        n_checks++;
        if (pd_cnt != nper) begin
            n_fail++;
            $display("FAIL period_done_count got %0d want %0d", pd_cnt, nper);
        end
        n_checks++;
        if (cd_cnt != (nper >= RNG ? 1 : 0)) begin
            n_fail++;
            $display("FAIL cycle_done_count got %0d want %0d", cd_cnt, nper >= RNG ? 1 : 0);
        end
        do_reset();
    endtask

    task automatic test_stop();
        @(negedge Clk);
        En = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        for (int j = 0; j < 4 * PER; j++) begin
            @(negedge Clk);
            if (j == 3 * PER + 40) En = 1'b0;
            n_checks++;
            if (pwmOut !== exp_pwm(j) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL stop_play j=%0d got pwm=%b busy=%b want %b 1", j, pwmOut, busy, exp_pwm(j));
            end
        end
        n_checks++;
        if (periodDone !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_last_pulse got %b want 1", periodDone);
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge Clk);
            n_checks++;
            if ({pwmOut, busy, periodDone, address} !== 10'd0) begin
                n_fail++;
                $display("FAIL stop_idle t=%0d got pwm=%b busy=%b pd=%b addr=%0d want 0 0 0 0",
                         j, pwmOut, busy, periodDone, address);
            end
        end
        tbl[0] = 8'd200;
        En = 1'b1;
        @(negedge Clk);
        n_checks++;
        if (busy !== 1'b1 || address !== 7'd0 || pwmOut !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_prime got busy=%b addr=%0d pwm=%b want 1 0 0", busy, address, pwmOut);
        end
        @(negedge Clk);
        n_checks++;
        if (sampleIdx !== 7'd0 || address !== 7'd0) begin
            n_fail++;
            $display("FAIL restart_run got idx=%0d addr=%0d want 0 0", sampleIdx, address);
        end
        @(negedge Clk);
        n_checks++;
        if (pwmOut !== 1'b1 || address !== 7'd1) begin
            n_fail++;
            $display("FAIL restart_sample0 got pwm=%b addr=%0d want 1 1", pwmOut, address);
        end
        do_reset();
    endtask

    task automatic test_async_reset();
        tbl[1] = 8'd255;
        @(negedge Clk);
        En = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        for (int j = 0; j < 2 * PER; j++) @(negedge Clk);
        n_checks++;
        if (periodDone !== 1'b1 || pwmOut !== 1'b1 || address !== 7'd2 || sampleIdx !== 7'd1) begin
            n_fail++;
            $display("FAIL pre_reset got pd=%b pwm=%b addr=%0d idx=%0d want 1 1 2 1",
                     periodDone, pwmOut, address, sampleIdx);
        end
        #2 Rst = 1'b1;
        #1;
        n_checks++;
        if ({address, sampleIdx, pwmOut, periodDone, cycleDone, busy} !== 18'd0) begin
            n_fail++;
            $display("FAIL async_reset got addr=%0d idx=%0d pwm=%b pd=%b cd=%b busy=%b want all 0",
                     address, sampleIdx, pwmOut, periodDone, cycleDone, busy);
        end
        @(posedge Clk);
        #1;
        n_checks++;
        if ({pwmOut, periodDone, busy} !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_held got pwm=%b pd=%b busy=%b want 0 0 0", pwmOut, periodDone, busy);
        end
        @(negedge Clk);
        Rst = 1'b0;
        En  = 1'b0;
    endtask

    task automatic test_range_one();
        int c, pd_cnt;
        bit ep;
        pd_cnt = 0;
        @(negedge Clk);
        En1 = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        for (int j = 0; j <= 3 * PER; j++) begin
            @(negedge Clk);
            c  = j % PER;
            ep = (j > 0) && (((j - 1) % PER) < int'(tbl1_0));
            if (periodDone1 === 1'b1) pd_cnt++;
            n_checks++;
            if (pwmOut1 !== ep) begin
                n_fail++;
                $display("FAIL r1_pwm j=%0d got %b want %b", j, pwmOut1, ep);
            end
            n_checks++;
            if (address1 !== 7'd0 || sampleIdx1 !== 7'd0 || busy1 !== 1'b1 || WR1 !== 1'b0) begin
                n_fail++;
                $display("FAIL r1_state j=%0d got addr=%0d idx=%0d busy=%b wr=%b want 0 0 1 0",
                         j, address1, sampleIdx1, busy1, WR1);
            end
            n_checks++;
            if (periodDone1 !== (c == PER - 1) || cycleDone1 !== (c == PER - 1)) begin
                n_fail++;
                $display("FAIL r1_pulses j=%0d got pd=%b cd=%b want %b", j, periodDone1, cycleDone1, c == PER - 1);
            end
        end
        n_checks++;
        if (pd_cnt != 3) begin
            n_fail++;
            $display("FAIL r1_period_count got %0d want 3", pd_cnt);
        end
        do_reset();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) tbl[i] = 8'(i);
        test_reset();
        test_playback(3);
        for (int i = 0; i < 128; i++) tbl[i] = 8'($urandom_range(0, 255));
        tbl[5] = 8'd128;
        tbl[6] = 8'd255;
        test_playback(101);
        for (int i = 0; i < 128; i++) tbl[i] = 8'(i);
        test_stop();
        test_async_reset();
        test_range_one();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
